i2s_capture_fifo: RTL
=====================

# i2s_capture_fifo

Capture-side buffer between the 22.579 MHz I2S receive path and the 100 MHz track store/load engine. Samples the left-channel word and word-select that arrive through the clock-crossing register, then detects each new frame on the synchronized rising edge of word-select. It writes exactly one sample per frame into a circular FIFO and presents the samples to the store engine over a valid/ready handshake. This replaces the level-sensitive write strobe with a single-pulse-per-frame write, and reports overflow when the store side stalls.

## Interface
Parameters:
- WORD_WIDTH, 8, sample width in bits; matches the I2S receiver word width.
- DEPTH, 16, number of FIFO entries; must be a power of two, at least 2.
- COUNT_WIDTH, 24, width of the accepted-sample counter.

Ports:
- clk  in  1  system clock (clk_100 domain).
- rst  in  1  synchronous, active-high reset.
- rec_en  in  1  record enable; when low, no samples are written.
- flush  in  1  single-cycle request to empty the FIFO and clear status.
- ws_in  in  1  word-select from the clock-crossing path; treated as asynchronous.
- sample_in  in  WORD_WIDTH  left-channel sample; stable for at least 8 clk cycles around each ws_in rising edge.
- dout  out  WORD_WIDTH  FIFO head sample (first-word fall-through).
- dout_valid  out  1  head sample is valid.
- dout_ready  in  1  consumer accepts the head sample this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one sample was dropped.
- sample_count  out  COUNT_WIDTH  number of samples accepted into the FIFO; saturates at all-ones.

## Operation
- Synchronizer: ws_in passes through two flops (s1, s2) and a history flop s3. ws_edge = s2 & ~s3. Only rising edges count; falling edges are ignored.
- Write request: wr = ws_edge & rec_en. At the clock edge where wr is high, sample_in is sampled.
- Pop: pop = dout_valid & dout_ready. When dout_valid is low, dout_ready has no effect.
- Storage: mem[DEPTH] with wr_ptr and rd_ptr of width $clog2(DEPTH); both pointers wrap modulo DEPTH.
  - dout = mem[rd_ptr], combinational read.
  - dout_valid = (level != 0).
- Write and pop cases:
  - wr while not full: write mem[wr_ptr], then wr_ptr+1, level+1, and sample_count+1 (saturating).
  - wr while full and pop in the same cycle: both execute; level stays at DEPTH; the sample is counted.
  - wr while full and no pop: the sample is dropped; overflow is set to 1; pointers, level and count do not change.
  - pop without wr: rd_ptr+1, level-1.
  - wr and pop when 0 < level < DEPTH: both execute; level does not change.
  - wr when level == 0: the sample is written; dout_valid goes high on the next cycle. No same-cycle bypass.
- flush: pointers and level go to 0, overflow goes to 0, sample_count goes to 0.
  - flush takes priority over a wr or pop in the same cycle; those requests are discarded.
  - Synchronizer flops are not cleared, so an edge already in flight is still seen on a later cycle.
- rec_en: sampled only together with ws_edge. If rec_en drops, the FIFO keeps draining. If rec_en rises while s2 is already high, no sample is written until the next rising edge.
- Reset: s1/s2/s3, pointers, level, overflow and sample_count all go to 0. dout_valid=0. dout is don't-care while dout_valid=0. Mem contents are not reset.
- Reset mid-operation: all contents are discarded. The first write after reset needs a fresh 0→1 transition of s2 relative to s3. Because s3 resets to 0, a ws_in already high at reset release yields exactly one edge.

## Timing
- ws_in first sampled high at edge k gives s1=1 at k and s2=1 at k+1. ws_edge is high during cycle k+1→k+2. The write happens at edge k+2. dout_valid is high after edge k+2. Latency from ws_in to valid is 3 edges.
- ws_edge lasts exactly one cycle per ws_in rising edge, provided ws_in holds each level for at least 2 clk cycles. At 44.1 kHz frames on a 100 MHz clock this gives about 2267 cycles per frame.
- A pop at edge n updates dout and level after edge n. Back-to-back pops on consecutive cycles are supported; throughput is 1 sample/cycle.
- overflow and sample_count update at the same edge as the write or drop that causes them.

## Test plan
- Single frame: reset, rec_en=1, sample_in=8'hA5, ws_in 0→1 at edge 10, dout_ready=0. Required: dout_valid=0 through edge 11; dout_valid=1, dout=8'hA5, level=1, sample_count=1 after edge 12.
- Ordering and wrap: 40 frames with sample_in=i; dout_ready pulsed so level stays ≤8. Required: dout sequence 0..39 in order with no gaps, pointers wrap twice, overflow=0, sample_count=40.
- Overflow: DEPTH=16, dout_ready=0, 18 frames with values 1..18. Required: level=16, overflow=1, sample_count=16. Draining yields 1..16; samples 17 and 18 are absent.
- Full with simultaneous wr+pop: FIFO full, dout_ready=1 exactly in the ws_edge cycle. Required: level stays 16, overflow stays 0, the oldest sample is popped, the new sample is appended.
- Gating and flush: rec_en=0 for 3 frames gives level=0 and sample_count=0. Then rec_en=1 for 5 frames, and flush asserted in the same cycle as a ws_edge. Required: level=0, overflow=0, sample_count=0; the frame coincident with flush is discarded.
- Reset mid-stream: rst asserted with level=7 and ws_in held high, then released. Required: level=0 and dout_valid=0 during reset. After release exactly one write occurs (s3 starts at 0), then no more until ws_in falls and rises again.

Source files
------------

// File: rtl/i2s_capture_fifo.sv
// Capture FIFO between the I2S receive path and the track store engine:
// one sample per rising word-select edge, FWFT valid/ready read side, sticky overflow.
module i2s_capture_fifo #(
    parameter int WORD_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rec_en,
    input  logic                       flush,
    input  logic                       ws_in,
    input  logic [WORD_WIDTH-1:0]      sample_in,
    output logic [WORD_WIDTH-1:0]      dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [COUNT_WIDTH-1:0]     sample_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [WORD_WIDTH-1:0]  mem [DEPTH];

    logic                   wsSync1_q, wsSync2_q, wsSync3_q;
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic wsEdge, wrReq, popReq, isFull, doWrite, doDrop;

    // Synchronizer is deliberately untouched by flush so an edge in flight survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wsSync1_q <= 1'b0;
            wsSync2_q <= 1'b0;
            wsSync3_q <= 1'b0;
        end else begin
            wsSync1_q <= ws_in;
            wsSync2_q <= wsSync1_q;
            wsSync3_q <= wsSync2_q;
        end
    end

    assign wsEdge  = wsSync2_q & ~wsSync3_q;
    assign wrReq   = wsEdge & rec_en;
    assign popReq  = dout_valid & dout_ready;
    assign isFull  = (level_q == FULL_LEVEL);
    assign doWrite = wrReq & (~isFull | popReq);
    assign doDrop  = wrReq & isFull & ~popReq;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        if (flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            count_d    = '0;
        end else begin
            if (doWrite) begin
                wrPtr_d = wrPtr_q + 1'b1;
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
            end
            if (popReq) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (doWrite && !popReq) begin
                level_d = level_q + 1'b1;
            end else if (!doWrite && popReq) begin
                level_d = level_q - 1'b1;
            end
            if (doDrop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    // Storage has no reset; validity is carried entirely by level.
    always_ff @(posedge clk) begin
        if (!rst && !flush && doWrite) begin
            mem[wrPtr_q] <= sample_in;
        end
    end

    assign dout         = mem[rdPtr_q];
    assign dout_valid   = (level_q != '0);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign sample_count = count_q;

endmodule
